// File: rtl/ndn_pkg.sv
// Shared types and constants for the NDN packet-buffer arbitration logic.
package ndn_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;
  localparam int IDX_W      = 2;

  localparam int REQ_PIT = 0;
  localparam int REQ_FIB = 1;
  localparam int REQ_SPI = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ndn_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping mod NREQ.
module ndn_rr_pick
  import ndn_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic             any,
  output logic [IDX_W-1:0] winner
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    any    = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDX_W'((int'(last) + i) % NREQ);
      if (!any && req[cand]) begin
        any    = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/ndn_mem_arbiter.sv
// Round-robin burst arbiter sharing one single-port packet buffer between NREQ engines.
module ndn_mem_arbiter
  import ndn_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_HOLD = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        rel,
  input  logic [NREQ-1:0]        we,
  input  logic [NREQ*ADDR_W-1:0] addr,
  input  logic [NREQ*DATA_W-1:0] wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [1:0]             owner,
  output logic                   busy,
  output logic                   timeout,
  output logic [DATA_W-1:0]      rdata,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic                   mem_we,
  input  logic [DATA_W-1:0]      mem_rdata
);

  arb_state_t       state, state_nx;
  logic [IDX_W-1:0] owner_q, last_q, winner;
  logic             any;
  logic [15:0]      hold_cnt;
  logic             timeout_q;
  logic             own_req, own_rel, hit_max, own_done;

  ndn_rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .last   (last_q),
    .any    (any),
    .winner (winner)
  );

  assign own_req  = req[owner_q];
  assign own_rel  = rel[owner_q];
  assign hit_max  = (hold_cnt == 16'(MAX_HOLD - 1));
  // Dropping req is an abort; rel and the hold limit both end the burst after this beat.
  assign own_done = !own_req || own_rel || hit_max;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (any)      state_nx = ST_OWN;
      ST_OWN:  if (own_done) state_nx = ST_GAP;
      ST_GAP:                state_nx = ST_IDLE;
      default:               state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q   <= '0;
      last_q    <= IDX_W'(NREQ - 1);
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      // A timeout only counts when neither rel nor an abort ended the burst first.
      timeout_q <= (state == ST_OWN) && own_req && !own_rel && hit_max;
      if (state == ST_IDLE && any) begin
        owner_q  <= winner;
        hold_cnt <= '0;
      end else if (state == ST_OWN) begin
        if (hold_cnt != 16'hFFFF) hold_cnt <= hold_cnt + 16'd1;
        if (own_done)             last_q   <= owner_q;
      end
    end
  end

  always_comb begin
    gnt       = '0;
    busy      = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (state == ST_OWN) begin
      gnt       = NREQ'(1) << owner_q;
      busy      = 1'b1;
      mem_addr  = addr[owner_q*ADDR_W +: ADDR_W];
      mem_wdata = wdata[owner_q*DATA_W +: DATA_W];
      mem_we    = we[owner_q] & own_req;
    end
  end

  assign owner   = owner_q;
  assign timeout = timeout_q;
  assign rdata   = mem_rdata;

endmodule

// File: tb/tb_ndn_mem_arbiter.sv
// Scoreboard bench for ndn_mem_arbiter: directed bursts with a behavioural 1024x8 buffer.
module tb_ndn_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req, rel, we;
  logic [29:0] addr;
  logic [23:0] wdata;
  logic [2:0]  gnt;
  logic [1:0]  owner;
  logic        busy, timeout;
  logic [7:0]  rdata;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [0:1023];
  logic        load_en;
  logic [9:0]  load_a;
  logic [7:0]  load_d;

  typedef struct {
    logic [9:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t wq[$];
  int  gq[$];
  int  tq[$];

  int checks = 0;
  int errors = 0;
  logic       prev_busy;
  logic [1:0] seen_owner;

  ndn_mem_arbiter #(.NREQ(3), .ADDR_W(10), .DATA_W(8), .MAX_HOLD(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .rel       (rel),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .owner     (owner),
    .busy      (busy),
    .timeout   (timeout),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (load_en)     mem[load_a]   <= load_d;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected grants, writes and timeouts as the DUT presents them.
  always @(negedge clk) begin
    prev_busy <= busy;
    if (!reset) begin
      if (gnt != 3'b000) chk("gnt_onehot", 32'($onehot(gnt)), 32'd1);
      if (busy && !prev_busy) begin
        if (gq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_grant: got owner %0d expected none", owner);
        end else begin
          int e;
          e = gq.pop_front();
          chk("grant_owner", 32'(owner), 32'(e));
          chk("grant_vec", 32'(gnt), 32'd1 << e);
        end
        seen_owner <= owner;
      end
      if (mem_we) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("write_addr", 32'(mem_addr), 32'(w.a));
          chk("write_data", 32'(mem_wdata), 32'(w.d));
        end
      end
      if (timeout) begin
        if (tq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_timeout: got pulse expected none");
        end else begin
          int e;
          e = tq.pop_front();
          chk("timeout_owner", 32'(seen_owner), 32'(e));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int r, input logic w, input logic [9:0] a,
                          input logic [7:0] d, input logic rl);
    we[r]            = w;
    addr[r*10 +: 10] = a;
    wdata[r*8 +: 8]  = d;
    rel[r]           = rl;
  endtask

  task automatic beats(input int r, input int n, input logic [9:0] a0, input logic [7:0] d0,
                       input logic w, input logic rel_last, input logic drop);
    for (int k = 0; k < n; k++) begin
      wr_t e;
      e.a = a0 + 10'(k);
      e.d = d0 + 8'(k);
      set_lane(r, w, e.a, e.d, rel_last && (k == n - 1));
      if (w) wq.push_back(e);
      cyc();
    end
    set_lane(r, 1'b0, 10'h0, 8'h0, 1'b0);
    if (drop) req[r] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seq [4];
    req = '0; rel = '0; we = '0; addr = '0; wdata = '0;
    load_en = 1'b0; load_a = '0; load_d = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    reset = 1'b0;
    load_en = 1'b1; load_a = 10'h3FF; load_d = 8'h5C;
    cyc();
    load_en = 1'b0;

    // Single requester; FIB/SPI present stray write data that must not leak.
    set_lane(1, 1'b1, 10'h030, 8'h11, 1'b0);
    set_lane(2, 1'b1, 10'h031, 8'h22, 1'b0);
    req = 3'b001; gq.push_back(0);
    cyc();
    chk("s1_latency_gnt", 32'(gnt), 32'b001);
    beats(0, 4, 10'd5, 8'hA0, 1'b1, 1'b1, 1'b1);
    chk("s1_gap_busy", 32'(busy), 32'd0);
    chk("s1_gap_gnt", 32'(gnt), 32'd0);
    chk("s1_gap_mem_addr", 32'(mem_addr), 32'd0);
    cyc();
    chk("s1_idle_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 4; k++) chk("s1_mem_content", 32'(mem[5 + k]), 32'hA0 + 32'(k));
    set_lane(1, 1'b0, 10'h0, 8'h0, 1'b0);
    set_lane(2, 1'b0, 10'h0, 8'h0, 1'b0);

    // Round-robin from a fresh reset so requester 0 leads.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    seq = '{0, 1, 2, 0};
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      gq.push_back(seq[i]);
      cyc();
      chk("s2_gnt", 32'(gnt), 32'd1 << seq[i]);
      beats(seq[i], 2, 10'h040 + 10'(i * 4), 8'hB0 + 8'(i * 2), 1'b1, 1'b1, 1'b0);
      chk("s2_gap_gnt", 32'(gnt), 32'd0);
      cyc();
      chk("s2_idle_busy", 32'(busy), 32'd0);
    end
    req = 3'b000;
    cyc();

    // Hold limit: FIB runs 8 beats with no rel, SPI waits.
    set_lane(2, 1'b1, 10'h2AA, 8'h77, 1'b0);
    req = 3'b110; gq.push_back(1);
    cyc();
    tq.push_back(1);
    beats(1, 8, 10'h100, 8'hC0, 1'b1, 1'b0, 1'b1);
    chk("s3_timeout_pulse", 32'(timeout), 32'd1);
    chk("s3_gap_gnt", 32'(gnt), 32'd0);
    gq.push_back(2);
    cyc();
    chk("s3_timeout_clear", 32'(timeout), 32'd0);
    cyc();
    chk("s3_next_gnt", 32'(gnt), 32'b100);
    beats(2, 1, 10'h2AA, 8'h77, 1'b1, 1'b1, 1'b1);
    cyc();

    // Abort: PIT drops req on beat 3 with we still high.
    req = 3'b001; gq.push_back(0);
    cyc();
    beats(0, 2, 10'h200, 8'hD0, 1'b1, 1'b0, 1'b0);
    set_lane(0, 1'b1, 10'h202, 8'hD2, 1'b0);
    req[0] = 1'b0;
    #1;
    chk("s4_abort_we", 32'(mem_we), 32'd0);
    cyc();
    chk("s4_gap_busy", 32'(busy), 32'd0);
    chk("s4_gap_timeout", 32'(timeout), 32'd0);
    set_lane(0, 1'b0, 10'h0, 8'h0, 1'b0);
    cyc();
    chk("s4_idle_timeout", 32'(timeout), 32'd0);

    // Read latency: last-beat read of 0x3FF is visible in the GAP cycle.
    req = 3'b010; gq.push_back(1);
    cyc();
    set_lane(1, 1'b0, 10'h3FF, 8'h00, 1'b1);
    cyc();
    chk("s5_gap_rdata", 32'(rdata), 32'h5C);
    req = 3'b000;
    set_lane(1, 1'b0, 10'h0, 8'h0, 1'b0);
    cyc();

    // Async reset on beat 2 of a planned 5-beat SPI burst.
    req = 3'b100; gq.push_back(2);
    cyc();
    beats(2, 1, 10'h050, 8'hE0, 1'b1, 1'b0, 1'b0);
    set_lane(2, 1'b1, 10'h051, 8'hE1, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    chk("s6_rst_gnt", 32'(gnt), 32'd0);
    chk("s6_rst_mem_we", 32'(mem_we), 32'd0);
    chk("s6_rst_busy", 32'(busy), 32'd0);
    chk("s6_rst_mem_addr", 32'(mem_addr), 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    set_lane(2, 1'b0, 10'h0, 8'h0, 1'b0);
    req = 3'b110; gq.push_back(1);
    cyc();
    chk("s6_post_rst_gnt", 32'(gnt), 32'b010);
    beats(1, 1, 10'h060, 8'hF0, 1'b1, 1'b1, 1'b1);
    req = 3'b000;
    cyc();
    cyc();

    chk("end_write_queue", 32'(wq.size()), 32'd0);
    chk("end_grant_queue", 32'(gq.size()), 32'd0);
    chk("end_timeout_queue", 32'(tq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
